cpu_stream_arbiter: RTL and testbench

CPU_STREAM_ARBITER -- requirements
Module: cpu_stream_arbiter

---
 rtl/cpu_stream_arbiter.sv | 130 +++++++++++++
 tb/tb_cpu_stream_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_stream_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_stream_arbiter
//
// Merges CPU_NB per-CPU valid/ready input streams into one registered output
// stream. Lanes are granted round-robin, one beat per cycle, with a single
// output register that can accept a new beat in the same cycle the held beat
// leaves (full throughput while out_rdy stays high). Each lane also counts
// the beats it has delivered downstream and raises a sticky done flag once
// TRANSACTION_NB beats have gone out.
//
// Ports
//   clk       : single clock, all state on the rising edge
//   rst       : synchronous, active-high reset
//   in_vld    : [CPU_NB]        per-lane valid
//   in_data   : [CPU_NB*DATA_W] lane i payload at [i*DATA_W +: DATA_W]
//   in_rdy    : [CPU_NB]        per-lane ready (combinational, one-hot or 0)
//   out_vld   : merged stream valid (registered)
//   out_data  : [DATA_W]        merged payload (registered)
//   out_idx   : [IDX_W]         source lane of out_data (registered)
//   out_rdy   : downstream ready
//   done      : [CPU_NB]        per-lane "TRANSACTION_NB beats delivered"
//   all_done  : AND of all done bits
// ----------------------------------------------------------------------------
module cpu_stream_arbiter #(
    parameter  int CPU_NB         = 4,
    parameter  int DATA_W         = 64,
    parameter  int TRANSACTION_NB = 1000,
    localparam int IDX_W          = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CPU_NB-1:0]        in_vld,
    input  logic [CPU_NB*DATA_W-1:0] in_data,
    output logic [CPU_NB-1:0]        in_rdy,
    output logic                     out_vld,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_idx,
    input  logic                     out_rdy,
    output logic [CPU_NB-1:0]        done,
    output logic                     all_done
);

    localparam logic [31:0]      CNT_MAX   = 32'(TRANSACTION_NB);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(CPU_NB - 1);

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  lane;
    logic              found;
    logic              any_vld;
    logic              load;
    logic              in_hs;
    logic              out_hs;
    logic [DATA_W-1:0] grant_data;
    logic [31:0]       cnt [CPU_NB];

    // Output register is free when empty or when its beat leaves this cycle.
    assign load    = !out_vld || out_rdy;
    assign any_vld = |in_vld;
    assign out_hs  = out_vld && out_rdy;

    // Round-robin search: first valid lane after the last granted one.
    // ptr starts at the last lane so lane 0 wins the first grant.
    always_comb begin
        grant = ptr;
        found = 1'b0;
        lane  = '0;
        for (int k = 1; k <= CPU_NB; k++) begin
            lane = IDX_W'((int'(ptr) + k) % CPU_NB);
            if (!found && in_vld[lane]) begin
                grant = lane;
                found = 1'b1;
            end
        end
    end

    assign grant_data = in_data[int'(grant)*DATA_W +: DATA_W];

    // grant only points at a valid lane when any_vld is set, so the single
    // asserted bit already implies in_vld for that lane.
    always_comb begin
        in_rdy = '0;
        if (!rst && load && any_vld) begin
            in_rdy[grant] = 1'b1;
        end
    end

    assign in_hs = |in_rdy;

    // Output register and arbitration pointer. A reset during a stall simply
    // drops the held beat; it never reaches out_hs, so no count is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_idx  <= '0;
            ptr      <= LAST_LANE;
        end else if (load) begin
            out_vld <= in_hs;
            if (in_hs) begin
                out_data <= grant_data;
                out_idx  <= grant;
                ptr      <= grant;
            end
        end
    end

    // Per-lane delivered-beat counters, saturating at TRANSACTION_NB.
    // done follows the counter by one cycle and is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CPU_NB; i++) begin
                cnt[i] <= '0;
            end
            done <= '0;
        end else begin
            for (int i = 0; i < CPU_NB; i++) begin
                if (out_hs && (out_idx == IDX_W'(i)) && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + 32'd1;
                end
                if (cnt[i] == CNT_MAX) begin
                    done[i] <= 1'b1;
                end
            end
        end
    end

    assign all_done = &done;

endmodule

// File: tb/tb_cpu_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cpu_stream_arbiter
//
// Two arbiters share one stimulus: dut_a with TRANSACTION_NB=3 and dut_b with
// TRANSACTION_NB=2. A round-robin reference model predicts in_rdy and pushes
// each expected beat into a scoreboard queue; the beat held in the output
// register is compared against the queue head and popped on delivery.
// ----------------------------------------------------------------------------
module tb_cpu_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    typedef struct {
        int          idx;
        logic [63:0] data;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_vld;
    logic [N*DW-1:0] in_data;
    logic            out_rdy;

    logic [N-1:0]    in_rdy_a, in_rdy_b, done_a, done_b;
    logic            out_vld_a, out_vld_b, all_done_a, all_done_b;
    logic [DW-1:0]   out_data_a, out_data_b;
    logic [1:0]      out_idx_a, out_idx_b;

    int total = 0;
    int bad   = 0;

    beat_t       sb[$];
    int          m_ptr;
    logic        m_full;
    int          m_cnt[N];
    logic [N-1:0] m_done_a, m_done_b;

    always #5 clk = ~clk;

    cpu_stream_arbiter #(.CPU_NB(N), .DATA_W(DW), .TRANSACTION_NB(3)) dut_a (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
        .in_rdy(in_rdy_a), .out_vld(out_vld_a), .out_data(out_data_a),
        .out_idx(out_idx_a), .out_rdy(out_rdy), .done(done_a),
        .all_done(all_done_a)
    );

    cpu_stream_arbiter #(.CPU_NB(N), .DATA_W(DW), .TRANSACTION_NB(2)) dut_b (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
        .in_rdy(in_rdy_b), .out_vld(out_vld_b), .out_data(out_data_b),
        .out_idx(out_idx_b), .out_rdy(out_rdy), .done(done_b),
        .all_done(all_done_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic [N-1:0] vld, input logic rdy);
        in_vld  = vld;
        out_rdy = rdy;
        for (int i = 0; i < N; i++) begin
            in_data[i*DW +: DW] = {$urandom, $urandom};
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr    = N - 1;
        m_full   = 1'b0;
        m_done_a = '0;
        m_done_b = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Called at posedge+1 with inputs already driven; returns at posedge+1.
    task automatic run_cycle();
        logic        load, any, ohs;
        int          g, l;
        logic [N-1:0] er;
        beat_t       b;
        #1;
        load = !m_full || out_rdy;
        g    = m_ptr;
        any  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            l = (m_ptr + k) % N;
            if (!any && in_vld[l]) begin
                g   = l;
                any = 1'b1;
            end
        end
        er = (!rst && load && any) ? N'(1 << g) : '0;
        check_val("in_rdy", in_rdy_a, er);
        check_val("out_vld", out_vld_a, m_full);
        if (m_full) begin
            check_val("sb_level", sb.size(), 1);
            if (sb.size() > 0) begin
                check_val("out_idx", out_idx_a, sb[0].idx);
                check_val("out_data", out_data_a, sb[0].data);
            end
        end
        check_val("done_a", done_a, m_done_a);
        check_val("all_done_a", all_done_a, &m_done_a);
        check_val("done_b", done_b, m_done_b);
        check_val("all_done_b", all_done_b, &m_done_b);
        ohs = m_full && out_rdy;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_cnt[i] >= 3) m_done_a[i] = 1'b1;
                if (m_cnt[i] >= 2) m_done_b[i] = 1'b1;
            end
            if (ohs && sb.size() > 0) begin
                b = sb.pop_front();
                m_cnt[b.idx]++;
            end
            if (er != '0) begin
                b.idx  = g;
                b.data = in_data[g*DW +: DW];
                sb.push_back(b);
                m_ptr = g;
            end
            if (load) m_full = (er != '0);
        end
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        set_inputs('1, rdy);
        @(posedge clk);
        #1;
        model_reset();
        repeat (2) run_cycle();
        rst = 1'b0;
        check_val("rst_data", out_data_a, 64'd0);
        check_val("rst_idx", out_idx_a, 64'd0);
    endtask

    initial begin
        model_reset();
        in_data = '0;
        do_reset(1'b1);

        // all lanes valid, full throughput: 0,1,2,3,0,...
        set_inputs('1, 1'b1);
        #1 check_val("first_grant", in_rdy_a, 4'b0001);
        check_val("first_vld", out_vld_a, 1'b0);
        for (int c = 0; c < 9; c++) begin
            set_inputs('1, 1'b1);
            run_cycle();
            if (c < 8) check_val("rr_seq", out_idx_a, c % 4);
        end

        // single lane 2 with a fixed payload
        do_reset(1'b1);
        set_inputs(4'b0100, 1'b1);
        in_data[2*DW +: DW] = 64'hDEAD_BEEF_0000_0002;
        #1 check_val("lane2_rdy", in_rdy_a, 4'b0100);
        run_cycle();
        set_inputs('0, 1'b1);
        check_val("lane2_data", out_data_a, 64'hDEADBEEF00000002);
        check_val("lane2_idx", out_idx_a, 2);
        run_cycle();

        // stall with lanes valid for 5 cycles, then release
        set_inputs('1, 1'b1);
        run_cycle();
        for (int c = 0; c < 5; c++) begin
            set_inputs('1, 1'b0);
            run_cycle();
        end
        for (int c = 0; c < 4; c++) begin
            set_inputs('1, 1'b1);
            run_cycle();
        end

        // lane 1 only: done_a after 3 deliveries, beats keep flowing
        do_reset(1'b1);
        for (int c = 0; c < 7; c++) begin
            set_inputs(4'b0010, 1'b1);
            run_cycle();
            if (c == 3) check_val("done_pre", done_a, 4'b0000);
            if (c == 4) check_val("done_lane1", done_a, 4'b0010);
            if (c == 6) check_val("done_sticky", done_a, 4'b0010);
        end

        // all lanes to TRANSACTION_NB, all_done rises with the last bit
        do_reset(1'b1);
        for (int c = 0; c < 16; c++) begin
            set_inputs('1, 1'b1);
            run_cycle();
        end
        check_val("all_done_b_end", all_done_b, 1'b1);
        check_val("all_done_a_end", all_done_a, 1'b1);

        // random traffic and backpressure
        for (int c = 0; c < 300; c++) begin
            set_inputs(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            run_cycle();
        end

        // reset in the middle of a stall drops the held beat
        set_inputs('1, 1'b1);
        run_cycle();
        for (int c = 0; c < 2; c++) begin
            set_inputs('1, 1'b0);
            run_cycle();
        end
        check_val("stall_vld", out_vld_a, 1'b1);
        rst = 1'b1;
        set_inputs('1, 1'b0);
        run_cycle();
        rst = 1'b0;
        check_val("mid_rst_vld", out_vld_a, 1'b0);
        check_val("mid_rst_done", done_a, 4'b0000);
        set_inputs('1, 1'b0);
        #1 check_val("mid_rst_grant", in_rdy_a, 4'b0001);
        run_cycle();
        // counters restart from zero: lane 1 needs two fresh deliveries
        for (int c = 0; c < 6; c++) begin
            set_inputs(4'b0010, 1'b1);
            run_cycle();
        end
        check_val("recount_b", done_b, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
